// File: rtl/tbre_pkg.sv
// Shared definitions for the TBRE background revocation sweep engine:
// FSM states, MMIO bus field offsets and the capability tag position.
package tbre_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_RW,
    ST_LK,
    ST_LW,
    ST_WR,
    ST_NEXT,
    ST_DONE
  } sweep_state_e;

  localparam int START_LSB   = 0;
  localparam int END_LSB     = 32;
  localparam int GO_BIT      = 64;

  localparam int BUSY_BIT    = 0;
  localparam int STAT_W      = 16;
  localparam int SCANNED_LSB = 16;
  localparam int REVOKED_LSB = 32;

  localparam int TAG_BIT     = 64;

  // Counters stick at all-ones instead of wrapping back to a small value.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == '1) ? v : v + STAT_W'(1);
  endfunction

endpackage

// File: rtl/tbre_sweep_engine.sv
// Background revocation sweep: walks [start, end) one capability word at a time and
// clears the tag of any word whose address is revoked. Define TBRE_SWEEP_STATS_EN for counters.
module tbre_sweep_engine
  import tbre_pkg::*;
#(
  parameter int AW   = 32,
  parameter int STEP = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [127:0]  mmreg_corein_i,
  output logic [63:0]   mmreg_coreout_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [64:0]   mem_wdata_o,
  input  logic          mem_gnt_i,
  input  logic          mem_rvalid_i,
  input  logic [64:0]   mem_rdata_i,
  output logic          rev_req_o,
  output logic [AW-1:0] rev_addr_o,
  input  logic          rev_gnt_i,
  input  logic          rev_valid_i,
  input  logic          rev_bit_i
);

  localparam logic [AW-1:0] ALIGN_MASK = ~AW'(STEP - 1);
  localparam logic [AW:0]   STEP_EXT   = (AW + 1)'(STEP);

  sweep_state_e  state_q, state_d;
  logic [AW-1:0] cur_q, end_q;
  logic [63:0]   data_q;
  logic          load_go, capture, advance;
  logic          go, busy;
  logic [AW-1:0] start_aligned, end_aligned;
  logic [AW:0]   next_sum;
  logic          unused_corein;

  assign go            = mmreg_corein_i[GO_BIT];
  assign start_aligned = mmreg_corein_i[START_LSB +: AW] & ALIGN_MASK;
  assign end_aligned   = mmreg_corein_i[END_LSB +: AW] & ALIGN_MASK;
  assign unused_corein = ^mmreg_corein_i[127:65];
  // The extra top bit catches a carry out of the address space so the sweep never wraps to 0.
  assign next_sum      = {1'b0, cur_q} + STEP_EXT;
  assign busy          = (state_q != ST_IDLE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    load_go     = 1'b0;
    capture     = 1'b0;
    advance     = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    rev_req_o   = 1'b0;
    rev_addr_o  = '0;
    case (state_q)
      ST_IDLE: begin
        if (go) begin
          load_go = 1'b1;
          state_d = (start_aligned >= end_aligned) ? ST_DONE : ST_RD;
        end
      end
      ST_RD: begin
        mem_req_o  = 1'b1;
        mem_addr_o = cur_q;
        if (mem_gnt_i) state_d = ST_RW;
      end
      ST_RW: begin
        if (mem_rvalid_i) begin
          capture = 1'b1;
          state_d = mem_rdata_i[TAG_BIT] ? ST_LK : ST_NEXT;
        end
      end
      ST_LK: begin
        rev_req_o  = 1'b1;
        rev_addr_o = data_q[AW-1:0];
        if (rev_gnt_i) state_d = ST_LW;
      end
      ST_LW: begin
        if (rev_valid_i) state_d = rev_bit_i ? ST_WR : ST_NEXT;
      end
      ST_WR: begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = cur_q;
        mem_wdata_o = {1'b0, data_q};
        if (mem_gnt_i) state_d = ST_NEXT;
      end
      ST_NEXT: begin
        advance = 1'b1;
        state_d = (next_sum[AW] || (next_sum[AW-1:0] >= end_q)) ? ST_DONE : ST_RD;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cur_q  <= '0;
      end_q  <= '0;
      data_q <= '0;
    end else begin
      if (load_go) begin
        cur_q <= start_aligned;
        end_q <= end_aligned;
      end else if (advance) begin
        cur_q <= next_sum[AW-1:0];
      end
      if (capture) data_q <= mem_rdata_i[63:0];
    end
  end

`ifdef TBRE_SWEEP_STATS_EN
  logic [STAT_W-1:0] scanned_q, revoked_q;

  // Counts cover the current sweep only; an accepted go starts them afresh.
  always_ff @(posedge clk_i) begin
    if (rst_i || load_go) begin
      scanned_q <= '0;
      revoked_q <= '0;
    end else begin
      if (advance) scanned_q <= sat_inc(scanned_q);
      if (state_q == ST_WR && mem_gnt_i) revoked_q <= sat_inc(revoked_q);
    end
  end

  always_comb begin
    mmreg_coreout_o                               = '0;
    mmreg_coreout_o[BUSY_BIT]                     = busy;
    mmreg_coreout_o[SCANNED_LSB +: STAT_W]        = scanned_q;
    mmreg_coreout_o[REVOKED_LSB +: STAT_W]        = revoked_q;
  end
`else
  always_comb begin
    mmreg_coreout_o           = '0;
    mmreg_coreout_o[BUSY_BIT] = busy;
  end
`endif

endmodule
